// File: rtl/in_block_buffer.sv
// Input-side staging buffer for the 3DES datapath: packs host word pairs into
// 64-bit blocks (first word low) and queues them show-ahead for the cipher core.
module in_block_buffer #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [31:0]      word_in,
    input  logic             word_valid,
    input  logic             pop,
    input  logic             clear,
    output logic [63:0]      block_out,
    output logic             block_valid,
    output logic             word_ready,
    output logic [CNT_W-1:0] block_count,
    output logic             overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [63:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_lo;
    logic               r_overrun;

    logic               w_word_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    // A low word is always accepted; only a completing high word needs room.
    assign w_word_ready = !(r_state == WAIT_HI && r_count == CNT_W'(DEPTH));
    assign w_accept     = word_valid && w_word_ready;
    assign w_push       = w_accept && (r_state == WAIT_HI) && !clear;
    assign w_pop        = pop && (r_count != '0) && !clear;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = WAIT_LO;
        end else if (w_accept) begin
            w_state_nxt = (r_state == WAIT_LO) ? WAIT_HI : WAIT_LO;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= WAIT_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the block storage is reset too, because block_out must read as zero straight after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_lo      <= '0;
            r_overrun <= 1'b0;
        end else if (clear) begin
            // Flush drops the pending low word via the FSM; stored data is left in place.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept && r_state == WAIT_LO) begin
                r_lo <= word_in;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= {word_in, r_lo};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (word_valid && !w_word_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign block_out   = r_mem[r_rd_ptr];
    assign block_valid = (r_count != '0);
    assign word_ready  = w_word_ready;
    assign block_count = r_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_in_block_buffer.sv
// Self-checking bench for in_block_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_in_block_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [31:0]      word_in = '0;
    logic             word_valid = 1'b0;
    logic             pop = 1'b0;
    logic             clear = 1'b0;
    logic [63:0]      block_out;
    logic             block_valid;
    logic             word_ready;
    logic [CNT_W-1:0] block_count;
    logic             overrun;

    int checks = 0;
    int failures = 0;

    in_block_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .pop         (pop),
        .clear       (clear),
        .block_out   (block_out),
        .block_valid (block_valid),
        .word_ready  (word_ready),
        .block_count (block_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole blocks plus a "half pair pending" flag.
    logic [63:0] m_q[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_lo = '0;
    bit          m_ov = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_q.delete();
            m_pend = 1'b0;
            m_lo   = '0;
            m_ov   = 1'b0;
        end else if (clear) begin
            m_q.delete();
            m_pend = 1'b0;
            m_ov   = 1'b0;
        end else begin
            bit ready;
            bit do_pop;
            ready  = !(m_pend && m_q.size() == DEPTH);
            do_pop = pop && m_q.size() > 0;
            if (do_pop) void'(m_q.pop_front());
            if (word_valid && !ready) m_ov = 1'b1;
            if (word_valid && ready) begin
                if (!m_pend) begin
                    m_lo   = word_in;
                    m_pend = 1'b1;
                end else begin
                    m_q.push_back({word_in, m_lo});
                    m_pend = 1'b0;
                end
            end
        end
    end

    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        if (run_cmp && n_rst) begin
            check("cmp_count", 64'(block_count), 64'(m_q.size()));
            check("cmp_valid", 64'(block_valid), 64'(m_q.size() != 0));
            check("cmp_ready", 64'(word_ready), 64'(!(m_pend && m_q.size() == DEPTH)));
            check("cmp_overrun", 64'(overrun), 64'(m_ov));
            if (m_q.size() != 0) check("cmp_block_out", block_out, m_q[0]);
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic cyc(input bit wv, input logic [31:0] w, input bit p, input bit c);
        word_valid = wv;
        word_in    = w;
        pop        = p;
        clear      = c;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic pair(input logic [31:0] lo, input logic [31:0] hi);
        cyc(1'b1, lo, 1'b0, 1'b0);
        cyc(1'b1, hi, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_block_out", block_out, 64'h0);
        check("rst_valid", 64'(block_valid), 64'h0);
        check("rst_ready", 64'(word_ready), 64'h1);
        check("rst_count", 64'(block_count), 64'h0);
        check("rst_overrun", 64'(overrun), 64'h0);
        n_rst = 1'b1;
        run_cmp = 1'b1;
        @(negedge clk);

        // 1: first pair
        cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        check("t1_count_after_lo", 64'(block_count), 64'h0);
        cyc(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        check("t1_valid", 64'(block_valid), 64'h1);
        check("t1_block", block_out, 64'h2222_2222_1111_1111);
        check("t1_count", 64'(block_count), 64'h1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_drained", 64'(block_count), 64'h0);

        // 2: fill, then a hi word is dropped while full
        for (int i = 0; i < DEPTH; i++) pair(32'hA000_0000 + i, 32'hB000_0000 + i);
        cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0);
        check("t2_ready_full", 64'(word_ready), 64'h0);
        check("t2_count_full", 64'(block_count), 64'h4);
        cyc(1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
        check("t2_overrun", 64'(overrun), 64'h1);
        check("t2_count", 64'(block_count), 64'h4);
        check("t2_head", block_out, 64'hB000_0000_A000_0000);

        // 3: pop from full while in WAIT_HI, then complete and drain
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t3_count", 64'(block_count), 64'h3);
        check("t3_ready", 64'(word_ready), 64'h1);
        cyc(1'b1, 32'hCAFE_0000, 1'b0, 1'b0);
        check("t3_count_refill", 64'(block_count), 64'h4);
        for (int i = 1; i < DEPTH; i++) begin
            check("t3_drain_order", block_out, {32'hB000_0000 + i, 32'hA000_0000 + i});
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("t3_last_block", block_out, 64'hCAFE_0000_5555_5555);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t3_empty_valid", 64'(block_valid), 64'h0);

        // 4: simultaneous push and pop at count 2
        pair(32'h10, 32'h20);
        pair(32'h30, 32'h40);
        cyc(1'b1, 32'h50, 1'b0, 1'b0);
        cyc(1'b1, 32'h60, 1'b1, 1'b0);
        check("t4_count", 64'(block_count), 64'h2);
        check("t4_head", block_out, 64'h0000_0040_0000_0030);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t4_next", block_out, 64'h0000_0060_0000_0050);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // 5: clear beats a same-cycle word and pop
        for (int i = 0; i < DEPTH; i++) pair(32'hC0 + i, 32'hD0 + i);
        cyc(1'b1, 32'h71, 1'b0, 1'b0);
        cyc(1'b1, 32'h72, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_pre_count", 64'(block_count), 64'h3);
        check("t5_pre_overrun", 64'(overrun), 64'h1);
        cyc(1'b1, 32'h77, 1'b1, 1'b1);
        check("t5_count", 64'(block_count), 64'h0);
        check("t5_valid", 64'(block_valid), 64'h0);
        check("t5_overrun", 64'(overrun), 64'h0);
        check("t5_ready", 64'(word_ready), 64'h1);
        pair(32'h81, 32'h82);
        check("t5_fresh", block_out, 64'h0000_0082_0000_0081);

        // 6: async reset between lo and hi words
        cyc(1'b1, 32'h91, 1'b0, 1'b0);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_count", 64'(block_count), 64'h0);
        check("t6_rst_block_out", block_out, 64'h0);
        n_rst = 1'b1;
        cyc(1'b1, 32'hA1, 1'b0, 1'b0);
        check("t6_count_after_hi", 64'(block_count), 64'h0);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        check("t6_block", block_out, 64'h0000_00A2_0000_00A1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t6_pop_empty", 64'(block_count), 64'h0);
        check("t6_pop_empty_valid", 64'(block_valid), 64'h0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
